// File: rtl/ram_single_port.sv
// ram_single_port: 2**ADDR_WIDTH x DATA_WIDTH storage with one write port
// and one independent read port on a single clock. READ_MODE selects the
// read architecture:
//   0 = asynchronous read
//   1 = synchronous read-first (registered data_out)
//   2 = registered read address, write-first
// Every word, and any read-side register, is cleared by an asynchronous
// active-high reset.

module ram_single_port #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8,
   parameter int READ_MODE  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_in,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Storage array: cleared on reset, written at enabled clock edges.
   // NOTE: the array sits inside the reset domain because reset must clear
   // every word; this keeps it as flops rather than an inferred RAM macro.
   // NOTE: reset takes priority, so a write at an edge where rst is high
   // is discarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_in) begin
         mem_q[write_addr] <= data_in;
      end
   end

   generate
      if (READ_MODE == 0) begin : g_async_read
         // Combinational read. A write shows on data_out right after the
         // edge that performs it.
         assign data_out = mem_q[read_addr];

      end else if (READ_MODE == 1) begin : g_sync_read_first
         logic [DATA_WIDTH-1:0] rd_data_d;
         logic [DATA_WIDTH-1:0] rd_data_q;

         // Look up the word that will be captured at the next edge.
         // NOTE: combinational logic uses blocking '='. Clocked state uses
         // non-blocking '<=', so on a read/write collision the read samples
         // the old word (read-first).
         always_comb begin
            rd_data_d = mem_q[read_addr];
         end

         // Output register gives one cycle of read latency.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data_q <= '0;
            end else begin
               rd_data_q <= rd_data_d;
            end
         end

         assign data_out = rd_data_q;

      end else if (READ_MODE == 2) begin : g_reg_addr_write_first
         logic [ADDR_WIDTH-1:0] rd_addr_d;
         logic [ADDR_WIDTH-1:0] rd_addr_q;

         // The next registered address is simply the current read address.
         always_comb begin
            rd_addr_d = read_addr;
         end

         // Register the read address. The array is read combinationally
         // behind it, so data_out shows a word written at the same edge
         // (write-first). It also follows later writes to that word.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_addr_q <= '0;
            end else begin
               rd_addr_q <= rd_addr_d;
            end
         end

         assign data_out = mem_q[rd_addr_q];

      end else begin : g_bad_read_mode
         $error("ram_single_port: READ_MODE must be 0, 1 or 2");
      end
   endgenerate

endmodule

// File: tb/tb_ram_single_port.sv
// tb_ram_single_port: drives all three READ_MODE variants from shared inputs.
// Stimulus pushes hand-computed expectations into a queue. A monitor pops
// one entry at each falling clock edge, or on an explicit mid-cycle probe
// event, and compares it against each variant's data_out.

module tb_ram_single_port;

   localparam int AW = 6;
   localparam int DW = 8;

   logic          clk;
   logic          rst;
   logic          we_in;
   logic [AW-1:0] write_addr;
   logic [DW-1:0] data_in;
   logic [AW-1:0] read_addr;
   logic [DW-1:0] dout0;
   logic [DW-1:0] dout1;
   logic [DW-1:0] dout2;

   typedef struct {
      string         name;
      logic [DW-1:0] e0;
      logic [DW-1:0] e1;
      logic [DW-1:0] e2;
   } exp_t;

   exp_t exp_q [$];
   int   n_checks;
   int   n_errors;
   event sample_ev;

   ram_single_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .we_in(we_in), .write_addr(write_addr),
      .data_in(data_in), .read_addr(read_addr), .data_out(dout0));

   ram_single_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .we_in(we_in), .write_addr(write_addr),
      .data_in(data_in), .read_addr(read_addr), .data_out(dout1));

   ram_single_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_MODE(2)) dut2 (
      .clk(clk), .rst(rst), .we_in(we_in), .write_addr(write_addr),
      .data_in(data_in), .read_addr(read_addr), .data_out(dout2));

   // 40-time-unit clock period: rising edges at 20, 60, ...
   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   task automatic check(input string name, input int mode,
                        input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s mode%0d: got 0x%02h expected 0x%02h (t=%0t)",
                  name, mode, act, exp, $time);
      end
   endtask

   // Monitor: compare every variant against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or sample_ev);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, 0, dout0, e.e0);
            check(e.name, 1, dout1, e.e1);
            check(e.name, 2, dout2, e.e2);
         end
      end
   end

   // Apply inputs just after a falling edge; they hold across the next rising edge.
   task automatic set_in(input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] din, input logic [AW-1:0] ra);
      @(negedge clk);
      #1;
      we_in      = we;
      write_addr = wa;
      data_in    = din;
      read_addr  = ra;
   endtask

   // Expectation checked at the falling edge after the coming rising edge.
   task automatic exp_edge(input string name, input logic [DW-1:0] e0,
                           input logic [DW-1:0] e1, input logic [DW-1:0] e2);
      exp_t e;
      e.name = name; e.e0 = e0; e.e1 = e1; e.e2 = e2;
      exp_q.push_back(e);
   endtask

   // Expectation checked right now, between clock edges.
   task automatic probe(input string name, input logic [DW-1:0] e0,
                        input logic [DW-1:0] e1, input logic [DW-1:0] e2);
      exp_edge(name, e0, e1, e2);
      ->sample_ev;
      #1;
   endtask

   task automatic step(input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] din, input logic [AW-1:0] ra,
                       input string name, input logic [DW-1:0] e0,
                       input logic [DW-1:0] e1, input logic [DW-1:0] e2);
      set_in(we, wa, din, ra);
      exp_edge(name, e0, e1, e2);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst        = 1'b0;
      we_in      = 1'b0;
      write_addr = '0;
      data_in    = '0;
      read_addr  = '0;

      // Reset fill-check: hold reset over two edges, then read 0, 31 and 63.
      #3 rst = 1'b1;
      repeat (2) @(posedge clk);
      #5;
      probe("reset_hold", 8'h00, 8'h00, 8'h00);
      set_in(1'b0, 6'd0, 8'h00, 6'd0);
      rst = 1'b0;
      exp_edge("reset_rd0", 8'h00, 8'h00, 8'h00);
      step(1'b0, 6'd0, 8'h00, 6'd31, "reset_rd31", 8'h00, 8'h00, 8'h00);
      step(1'b0, 6'd0, 8'h00, 6'd63, "reset_rd63", 8'h00, 8'h00, 8'h00);

      // Sequential write with a same-address read: mode 1 sees the old 0,
      // while modes 0 and 2 see the new word.
      for (int i = 0; i < 64; i++) begin
         step(1'b1, AW'(i), DW'(i), AW'(i), "seq_write_collide",
              DW'(i), 8'h00, DW'(i));
      end

      // Readback of addresses 0..10.
      for (int i = 0; i <= 10; i++) begin
         step(1'b0, 6'd0, 8'h00, AW'(i), "seq_read", DW'(i), DW'(i), DW'(i));
      end

      // Address change before the edge: mode 0 follows at once; modes 1/2
      // still show address 10 until the edge.
      set_in(1'b0, 6'd0, 8'h00, 6'd2);
      #4;
      probe("addr_latency_pre", 8'h02, 8'h0A, 8'h0A);
      exp_edge("addr_latency_post", 8'h02, 8'h02, 8'h02);

      // Write disable: data_in/write_addr are ignored when we_in=0.
      repeat (3) step(1'b0, 6'd5, 8'hAA, 6'd5, "we_off", 8'h05, 8'h05, 8'h05);

      // Read/write collision on address 7.
      step(1'b1, 6'd7, 8'h3C, 6'd7, "collision", 8'h3C, 8'h07, 8'h3C);
      step(1'b0, 6'd0, 8'h00, 6'd7, "collision_next", 8'h3C, 8'h3C, 8'h3C);

      // Top and bottom addresses.
      step(1'b1, 6'd63, 8'hFF, 6'd0, "top_wr63", 8'h00, 8'h00, 8'h00);
      step(1'b1, 6'd0, 8'h01, 6'd63, "top_rd63", 8'hFF, 8'hFF, 8'hFF);
      step(1'b0, 6'd0, 8'h00, 6'd0, "top_rd0", 8'h01, 8'h01, 8'h01);
      step(1'b0, 6'd0, 8'h00, 6'd62, "untouched62", 8'h3E, 8'h3E, 8'h3E);
      step(1'b0, 6'd0, 8'h00, 6'd1, "untouched1", 8'h01, 8'h01, 8'h01);
      step(1'b0, 6'd0, 8'h00, 6'd7, "untouched7", 8'h3C, 8'h3C, 8'h3C);
      step(1'b0, 6'd0, 8'h00, 6'd10, "untouched10", 8'h0A, 8'h0A, 8'h0A);

      // Reset mid-operation with a pending write of 0x55 to address 9.
      set_in(1'b1, 6'd9, 8'h55, 6'd9);
      #4 rst = 1'b1;
      #1;
      probe("async_reset", 8'h00, 8'h00, 8'h00);
      exp_edge("reset_across_edge", 8'h00, 8'h00, 8'h00);
      set_in(1'b0, 6'd0, 8'h00, 6'd9);
      rst = 1'b0;
      exp_edge("write_lost", 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 64; i++) begin
         step(1'b0, 6'd0, 8'h00, AW'(i), "post_reset_zero", 8'h00, 8'h00, 8'h00);
      end

      // Let the monitor consume the last expectation.
      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_single_port.md
Name: ram_single_port

Overview:
- Single-port-clock RAM: 64 words x 8 bits by default, one write port and one independent read port.
- Generic on-chip storage block; replaces the separate v1/v2/v3 RAM variants.
- The variant is selected by the READ_MODE parameter:
  - 0 = asynchronous read (v1 behaviour)
  - 1 = synchronous read-first (v2 behaviour)
  - 2 = registered read address, write-first (v3 behaviour)

Parameters:
- ADDR_WIDTH, 6: width of read_addr and write_addr; depth is 2**ADDR_WIDTH (64).
- DATA_WIDTH, 8: width of data_in, data_out and each memory word.
- READ_MODE, 1: read architecture, 0/1/2 as in Overview; any other value is a compile-time error.

Ports:
- clk  input  1  clock; all state updates occur on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- we_in  input  1  write enable, sampled at the rising edge of clk.
- write_addr  input  ADDR_WIDTH  write address.
- data_in  input  DATA_WIDTH  write data.
- read_addr  input  ADDR_WIDTH  read address.
- data_out  output  DATA_WIDTH  read data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset (rst=1, takes effect immediately, independent of clk):
  - All 2**ADDR_WIDTH memory words are cleared to 0.
  - data_out register (mode 1) is cleared to 0.
  - Registered read address (mode 2) is cleared to 0.
  - data_out reads 0 in every mode while rst=1 and until the first write.
- Write: at a rising clk edge with rst=0 and we_in=1, mem[write_addr] <= data_in.
  - we_in=0: memory is unchanged; data_in and write_addr are ignored.
  - Reset asserted at or across a clock edge: any write at that edge is discarded.
- Read is independent of we_in and is always active.
- READ_MODE 0:
  - data_out = mem[read_addr], combinational, zero latency.
  - A write to the addressed word shows on data_out right after the writing edge.
- READ_MODE 1:
  - data_out <= mem[read_addr] at every rising edge; one-cycle latency.
  - Read/write collision (read_addr==write_addr, we_in=1, same edge): data_out gets the OLD contents (read-first). The new value is returned on the following edge.
- READ_MODE 2:
  - read_addr_q <= read_addr at every rising edge; data_out = mem[read_addr_q].
  - One-cycle address latency.
  - Collision: data_out shows the NEW data after the edge (write-first).
  - data_out also follows later writes to the word at read_addr_q without a new address.
- Address range: the full 0..2**ADDR_WIDTH-1 range is valid. There is no out-of-range case, no wrap logic and no error flag.
- No handshake; one write and one read may proceed every cycle.
- Implementation: register array plus read logic; no vendor macros.

Test Plan:
- Reset fill-check:
  - Assert rst for 2 cycles, release, then read addresses 0, 31 and 63.
  - data_out = 0x00 for each, honouring the mode latency (0 or 1 cycle).
- Sequential write and readback:
  - we_in=1; for i=0..63 write write_addr=i, data_in=i, one per 40-time-unit step.
  - we_in=0; read addresses 0..10.
  - data_out = 0..10 respectively: immediately in mode 0, one edge later in modes 1/2.
- Write disable:
  - With mem[5]=0x05, drive we_in=0, write_addr=5, data_in=0xAA over 3 edges.
  - Reading addr 5 returns 0x05.
- Collision:
  - mem[7]=0x07; in the same cycle drive we_in=1, write_addr=7, data_in=0x3C, read_addr=7.
  - Mode 0 and mode 2: data_out=0x3C after the edge.
  - Mode 1: data_out=0x07 after that edge, 0x3C after the next edge.
- Top address:
  - Write 0xFF to addr 63 and 0x01 to addr 0.
  - Reads return 0xFF and 0x01; no other word is changed.
- Reset mid-operation:
  - Assert rst asynchronously between edges while we_in=1 and data_in=0x55.
  - data_out goes to 0 without waiting for a clock edge; all words read 0 afterwards; the pending write is lost.
